// File: rtl/hs_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | hs_rr_arbiter: four-phase handshake round-robin arbiter, N:1 onto one      |
// | downstream channel. Optional HS_ARB_SYNC_EN adds 2-flop req/ack syncs.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module hs_rr_arbiter #(
    parameter int N  = 4,
    parameter int DW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_i,
    output logic [N-1:0]      ack_o,
    input  logic [N*DW-1:0]   dat_i,
    output logic              req_o,
    input  logic              ack_i,
    output logic [DW-1:0]     dat_o,
    output logic [N-1:0]      grant_o,
    output logic              busy_o,
    output logic [7:0]        txn_cnt_o
);

    localparam int c_IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FWD   = 2'd1,
        S_ACKUP = 2'd2,
        S_RTZ   = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_ptr;
    logic [c_IW-1:0]   r_win;
    logic [N-1:0]      w_req;
    logic              w_ack;
    logic [N-1:0]      w_cand;
    logic              w_hit_hi;
    logic              w_hit_lo;
    logic [c_IW-1:0]   w_sel_hi;
    logic [c_IW-1:0]   w_sel_lo;
    logic [c_IW-1:0]   w_sel;
    logic [DW-1:0]     w_dat_sel;
    logic [N-1:0]      w_grant_sel;
    logic [c_IW-1:0]   w_ptr_nxt;

`ifdef HS_ARB_SYNC_EN
    logic [N-1:0] r_req_s1;
    logic [N-1:0] r_req_s2;
    logic         r_ack_s1;
    logic         r_ack_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_s1 <= '0;
            r_req_s2 <= '0;
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
        end else begin
            r_req_s1 <= req_i;
            r_req_s2 <= r_req_s1;
            r_ack_s1 <= ack_i;
            r_ack_s2 <= r_ack_s1;
        end
    end

    assign w_req = r_req_s2;
    assign w_ack = r_ack_s2;
`else
    assign w_req = req_i;
    assign w_ack = ack_i;
`endif

    assign w_cand = w_req & ~ack_o;

    // Lowest requester at or above ptr wins; otherwise lowest overall (wrap).
    always_comb begin
        w_hit_hi    = 1'b0;
        w_hit_lo    = 1'b0;
        w_sel_hi    = '0;
        w_sel_lo    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_hit_lo = 1'b1;
                w_sel_lo = c_IW'(i);
                if (c_IW'(i) >= r_ptr) begin
                    w_hit_hi = 1'b1;
                    w_sel_hi = c_IW'(i);
                end
            end
        end
        w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;
    end

    always_comb begin
        w_dat_sel   = '0;
        w_grant_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (c_IW'(k) == w_sel) begin
                w_dat_sel      = dat_i[k*DW +: DW];
                w_grant_sel[k] = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (r_win == c_IW'(N - 1)) ? '0 : r_win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            req_o     <= 1'b0;
            ack_o     <= '0;
            grant_o   <= '0;
            busy_o    <= 1'b0;
            dat_o     <= '0;
            txn_cnt_o <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit_lo) begin
                        r_win   <= w_sel;
                        dat_o   <= w_dat_sel;
                        grant_o <= w_grant_sel;
                        req_o   <= 1'b1;
                        busy_o  <= 1'b1;
                        r_state <= S_FWD;
                    end
                end
                S_FWD: begin
                    if (w_ack) begin
                        ack_o   <= grant_o;
                        r_state <= S_ACKUP;
                    end
                end
                S_ACKUP: begin
                    if ((w_req & grant_o) == '0) begin
                        req_o   <= 1'b0;
                        r_state <= S_RTZ;
                    end
                end
                S_RTZ: begin
                    if (!w_ack) begin
                        ack_o     <= '0;
                        grant_o   <= '0;
                        busy_o    <= 1'b0;
                        r_ptr     <= w_ptr_nxt;
                        txn_cnt_o <= txn_cnt_o + 8'd1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/hs_rr_arbiter.md
HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 Parameter N, default 4, SHALL set the number of requester channels (2..8).
REQ-002 Parameter DW, default 1, SHALL set the per-channel data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_i  input  N  SHALL carry the four-phase request from each requester.
REQ-006 ack_o  output  N  SHALL carry the four-phase acknowledge to each requester.
REQ-007 dat_i  input  N*DW  SHALL carry requester data; channel k occupies bits [k*DW +: DW].
REQ-008 req_o  output  1  SHALL carry the request on the shared downstream channel.
REQ-009 ack_i  input  1  SHALL carry the acknowledge from the shared downstream channel.
REQ-010 dat_o  output  DW  SHALL carry the granted requester's data downstream.
REQ-011 grant_o  output  N  SHALL be the one-hot grant vector; all zero when idle.
REQ-012 busy_o  output  1  SHALL be high in every state except IDLE.
REQ-013 txn_cnt_o  output  8  SHALL count completed transactions.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states SHALL be IDLE, FWD, ACKUP, RTZ.
REQ-016 IDLE: when any sampled req_i bit is high and the corresponding ack_o bit is low, the block SHALL select the winner w, capture dat_i[w] into dat_o, set grant_o[w], assert req_o, and enter FWD on the next edge.
REQ-017 Winner selection SHALL be round-robin: the first asserted request found searching upward from pointer ptr, wrapping from N-1 to 0.
REQ-018 FWD: on sampled ack_i=1 the block SHALL assert ack_o[w] and enter ACKUP.
REQ-019 ACKUP: on sampled req_i[w]=0 the block SHALL deassert req_o and enter RTZ.
REQ-020 RTZ: on sampled ack_i=0 the block SHALL perform all of the following on the same edge, then enter IDLE:
- deassert ack_o[w];
- clear grant_o;
- set ptr to (w+1) mod N;
- increment txn_cnt_o, wrapping from 255 to 0.
REQ-021 dat_o and grant_o SHALL be held constant from the IDLE exit until the RTZ exit, regardless of dat_i changes.
REQ-022 Requests from non-granted channels SHALL be ignored outside IDLE.
REQ-023 Latency (macro absent): req_i rise to req_o rise SHALL be 1 cycle, and ack_i rise to ack_o[w] rise SHALL be 1 cycle.
REQ-024 A request withdrawn before being sampled in IDLE SHALL produce no transaction.
REQ-025 The block SHALL start no new transaction in the cycle it returns to IDLE; the earliest re-grant is the following edge.
REQ-026 ack_i high while in IDLE SHALL be ignored.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force the following, and SHALL hold them while rst_n is low:
- state = IDLE, ptr = 0;
- req_o = 0, ack_o = 0, grant_o = 0, busy_o = 0;
- dat_o = 0, txn_cnt_o = 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction without an increment of txn_cnt_o.
REQ-029 After reset release, the first grant SHALL follow the REQ-017 search starting from channel 0.

Configuration
REQ-030 With macro HS_ARB_SYNC_EN defined, req_i and ack_i SHALL each pass through a two-flop synchronizer reset to 0, and all FSM decisions SHALL use the synchronized values.
REQ-031 With HS_ARB_SYNC_EN defined, each latency in REQ-023 SHALL be 3 cycles.
REQ-032 With HS_ARB_SYNC_EN undefined, req_i and ack_i SHALL be sampled directly, with no synchronizer flops.

Verification
REQ-033 Single transaction: N=4, req_i=0001, dat_i[0]=1, downstream acks after 2 cycles, requester drops req on ack_o[0] -> req_o rises 1 cycle after req_i, dat_o=1, grant_o=0001, txn_cnt_o=1, final state IDLE.
REQ-034 Contention: req_i=1111 held continuously, with prompt handshakes -> grant order 0,1,2,3,0, and txn_cnt_o=5 after five transactions.
REQ-035 Wrap: ptr=3 with requests on channels 1 and 2 -> channel 1 is granted first, then channel 2.
REQ-036 Data hold: dat_i[2] toggles during FWD/ACKUP of a channel-2 transaction -> dat_o stays at its captured value.
REQ-037 Mid-operation reset: rst_n pulled low while in ACKUP -> all outputs are 0 within the same cycle, txn_cnt_o=0, and the next grant goes to the lowest requesting channel.
REQ-038 Counter wrap: 256 transactions -> txn_cnt_o returns to 0; with HS_ARB_SYNC_EN defined, req_i to req_o latency measures 3 cycles.
